// File: rtl/reservation_station.sv
// reservation_station: 16-entry ALU reservation station. Instructions issue
// into the lowest free entry. Pending operands snoop the ALU and load/store
// common data buses (the ALU bus wins on a tag tie). One ready entry is
// dispatched per cycle onto registered outputs.
// Build macro RS_OLDEST_FIRST_EN: dispatch the oldest ready entry, using a
// per-entry age rank. Without it, the lowest-index ready entry dispatches.
module reservation_station (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  output logic        RS_Full,
  input  logic        Issue_S,
  input  logic [5:0]  Issue_Op,
  input  logic [31:0] Issue_Vj,
  input  logic [31:0] Issue_Vk,
  input  logic [4:0]  Issue_Qj,
  input  logic [4:0]  Issue_Qk,
  input  logic [31:0] Issue_A,
  input  logic [31:0] Issue_pc,
  input  logic [3:0]  Issue_Reorder,
  input  logic        CDB_ALU_S,
  input  logic [3:0]  CDB_ALU_Reorder,
  input  logic [31:0] CDB_ALU_Value,
  input  logic        CDB_LS_S,
  input  logic [3:0]  CDB_LS_Reorder,
  input  logic [31:0] CDB_LS_Value,
  input  logic        Clear,
  output logic        ALU_S,
  output logic [5:0]  Op,
  output logic [31:0] Vj,
  output logic [31:0] Vk,
  output logic [3:0]  Reorder,
  output logic [31:0] A,
  output logic [31:0] pc
);
  localparam int N = 16;

  logic [N-1:0] busy_q, busy_d;
  logic [5:0]   op_q  [N];
  logic [5:0]   op_d  [N];
  logic [31:0]  vj_q  [N];
  logic [31:0]  vj_d  [N];
  logic [31:0]  vk_q  [N];
  logic [31:0]  vk_d  [N];
  logic [4:0]   qj_q  [N];
  logic [4:0]   qj_d  [N];
  logic [4:0]   qk_q  [N];
  logic [4:0]   qk_d  [N];
  logic [31:0]  a_q   [N];
  logic [31:0]  a_d   [N];
  logic [31:0]  pc_q  [N];
  logic [31:0]  pc_d  [N];
  logic [3:0]   rob_q [N];
  logic [3:0]   rob_d [N];
`ifdef RS_OLDEST_FIRST_EN
  logic [3:0]   rank_q [N];
  logic [3:0]   rank_d [N];
  logic [4:0]   best_rank;
  logic [4:0]   busy_cnt;
  logic [4:0]   new_rank;
`endif

  logic [N-1:0] ready;
  logic         disp_vld;
  logic [3:0]   disp_idx;
  logic [3:0]   free_idx;
  logic         issue_go;

  logic         alu_s_q;
  logic [5:0]   dsp_op_q;
  logic [31:0]  dsp_vj_q, dsp_vk_q, dsp_a_q, dsp_pc_q;
  logic [3:0]   dsp_rob_q;

  // Resolve one operand against this cycle's broadcasts: {tag, value}.
  function automatic logic [36:0] snoop(input logic [4:0] q, input logic [31:0] v);
    logic [36:0] r;
    r = {q, v};
    if (q[4] && CDB_ALU_S && (CDB_ALU_Reorder == q[3:0]))
      r = {1'b0, q[3:0], CDB_ALU_Value};
    else if (q[4] && CDB_LS_S && (CDB_LS_Reorder == q[3:0]))
      r = {1'b0, q[3:0], CDB_LS_Value};
    return r;
  endfunction

  assign RS_Full  = &busy_q;
  assign issue_go = rdy && !Clear && Issue_S && !RS_Full;

  // Pick the entry to dispatch and the free slot for an incoming issue.
  always_comb begin
    ready    = '0;
    free_idx = '0;
    disp_idx = '0;
    for (int i = 0; i < N; i++)
      ready[i] = busy_q[i] && !qj_q[i][4] && !qk_q[i][4];
    disp_vld = |ready;
    for (int i = N - 1; i >= 0; i--)
      if (!busy_q[i]) free_idx = 4'(i);
`ifdef RS_OLDEST_FIRST_EN
    best_rank = 5'h1F;
    for (int i = 0; i < N; i++)
      if (ready[i] && ({1'b0, rank_q[i]} < best_rank)) begin
        best_rank = {1'b0, rank_q[i]};
        disp_idx  = 4'(i);
      end
`else
    for (int i = N - 1; i >= 0; i--)
      if (ready[i]) disp_idx = 4'(i);
`endif
  end

  // Entry next state: flush, CDB wakeup, dispatch release and issue write.
  always_comb begin
    busy_d = busy_q;
    op_d   = op_q;
    vj_d   = vj_q;
    vk_d   = vk_q;
    qj_d   = qj_q;
    qk_d   = qk_q;
    a_d    = a_q;
    pc_d   = pc_q;
    rob_d  = rob_q;
`ifdef RS_OLDEST_FIRST_EN
    rank_d   = rank_q;
    busy_cnt = '0;
    for (int i = 0; i < N; i++)
      busy_cnt = busy_cnt + {4'b0, busy_q[i]};
    new_rank = busy_cnt - {4'b0, disp_vld};
`endif
    if (Clear) begin
      busy_d = '0;
    end else if (rdy) begin
      for (int i = 0; i < N; i++)
        if (busy_q[i]) begin
          {qj_d[i], vj_d[i]} = snoop(qj_q[i], vj_q[i]);
          {qk_d[i], vk_d[i]} = snoop(qk_q[i], vk_q[i]);
        end
      if (disp_vld) begin
        busy_d[disp_idx] = 1'b0;
`ifdef RS_OLDEST_FIRST_EN
        for (int i = 0; i < N; i++)
          if (busy_q[i] && (rank_q[i] > rank_q[disp_idx]))
            rank_d[i] = rank_q[i] - 4'd1;
`endif
      end
      if (issue_go) begin
        busy_d[free_idx] = 1'b1;
        op_d[free_idx]   = Issue_Op;
        a_d[free_idx]    = Issue_A;
        pc_d[free_idx]   = Issue_pc;
        rob_d[free_idx]  = Issue_Reorder;
        {qj_d[free_idx], vj_d[free_idx]} = snoop(Issue_Qj, Issue_Vj);
        {qk_d[free_idx], vk_d[free_idx]} = snoop(Issue_Qk, Issue_Vk);
`ifdef RS_OLDEST_FIRST_EN
        rank_d[free_idx] = new_rank[3:0];
`endif
      end
    end
  end

  // Entry payload; only meaningful while the entry is busy, so no reset.
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    vj_q  <= vj_d;
    vk_q  <= vk_d;
    qj_q  <= qj_d;
    qk_q  <= qk_d;
    a_q   <= a_d;
    pc_q  <= pc_d;
    rob_q <= rob_d;
`ifdef RS_OLDEST_FIRST_EN
    rank_q <= rank_d;
`endif
  end

  // Busy vector; reset discards every in-flight entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  // Dispatch output register; ALU_S pulses for one cycle per dispatch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_s_q   <= 1'b0;
      dsp_op_q  <= '0;
      dsp_vj_q  <= '0;
      dsp_vk_q  <= '0;
      dsp_rob_q <= '0;
      dsp_a_q   <= '0;
      dsp_pc_q  <= '0;
    end else if (Clear || !rdy) begin
      alu_s_q <= 1'b0;
    end else begin
      alu_s_q <= disp_vld;
      if (disp_vld) begin
        dsp_op_q  <= op_q[disp_idx];
        dsp_vj_q  <= vj_q[disp_idx];
        dsp_vk_q  <= vk_q[disp_idx];
        dsp_rob_q <= rob_q[disp_idx];
        dsp_a_q   <= a_q[disp_idx];
        dsp_pc_q  <= pc_q[disp_idx];
      end
    end
  end

  assign ALU_S   = alu_s_q;
  assign Op      = dsp_op_q;
  assign Vj      = dsp_vj_q;
  assign Vk      = dsp_vk_q;
  assign Reorder = dsp_rob_q;
  assign A       = dsp_a_q;
  assign pc      = dsp_pc_q;

endmodule
